// File: rtl/dadda_tree_scheduler_if.sv
// Signal bundle between the Dadda tree scheduler, its requesters and the shared compressor tree.
interface dadda_tree_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int OUT_W   = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      tree_valid;
    logic [DATA_W-1:0]         tree_a;
    logic [DATA_W-1:0]         tree_b;
    logic [OUT_W-1:0]          tree_vec0;
    logic [OUT_W-1:0]          tree_vec1;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [NUM_REQ*OUT_W-1:0]  rsp_data;
    logic [NUM_REQ-1:0]        busy;

    modport slave (
        input  req_valid, req_a, req_b, tree_vec0, tree_vec1, rsp_ready,
        output req_ready, tree_valid, tree_a, tree_b, rsp_valid, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, tree_vec0, tree_vec1, rsp_ready,
        input  req_ready, tree_valid, tree_a, tree_b, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/dadda_tree_scheduler.sv
// Round-robin front end for a shared pipelined Dadda tree: one launch per cycle, ID tags follow the
// operands through the tree, and the carry-propagated result is parked per requester until popped.
module dadda_tree_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 16,
    parameter int OUT_W    = 32,
    parameter int TREE_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dadda_tree_scheduler_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Stage 0 shadows the launch register; TREE_LAT more stages line the tag up with the tree output.
    localparam int TAG_DEPTH = TREE_LAT + 1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]          rr_ptr_r;
    logic [NUM_REQ-1:0]       busy_r;
    logic [NUM_REQ-1:0]       rsp_valid_r;
    logic [OUT_W-1:0]         slot_r [NUM_REQ];
    logic                     tree_valid_r;
    logic [DATA_W-1:0]        tree_a_r;
    logic [DATA_W-1:0]        tree_b_r;
    logic [TAG_DEPTH-1:0]     tag_vld_r;
    logic [ID_W-1:0]          tag_id_r [TAG_DEPTH];

    logic [NUM_REQ-1:0]       eligible_s;
    logic [NUM_REQ-1:0]       grant_s;
    logic                     grant_any_s;
    logic [ID_W-1:0]          winner_s;
    logic [ID_W-1:0]          rr_next_s;
    logic [DATA_W-1:0]        win_a_s;
    logic [DATA_W-1:0]        win_b_s;
    logic [NUM_REQ-1:0]       pop_s;
    logic                     retire_s;
    logic [ID_W-1:0]          retire_id_s;
    logic [OUT_W-1:0]         sum_s;
    logic [NUM_REQ*OUT_W-1:0] rsp_data_s;

    // Round-robin search from rr_ptr over requesters that are valid and have nothing outstanding
    always_comb begin
        logic [ID_W:0] idx_v;
        logic          hit_v;
        eligible_s  = bus.req_valid & ~busy_r;
        grant_any_s = 1'b0;
        winner_s    = '0;
        idx_v       = '0;
        hit_v       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v       = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
            idx_v       = (idx_v >= (ID_W+1)'(NUM_REQ)) ? idx_v - (ID_W+1)'(NUM_REQ) : idx_v;
            hit_v       = !grant_any_s && eligible_s[idx_v[ID_W-1:0]];
            winner_s    = hit_v ? idx_v[ID_W-1:0] : winner_s;
            grant_any_s = grant_any_s | hit_v;
        end
    end

    // One-hot grant, pointer advance, winner operand mux and result unpacking
    always_comb begin
        grant_s    = '0;
        win_a_s    = '0;
        win_b_s    = '0;
        rsp_data_s = '0;
        if (grant_any_s && rst_n) begin
            grant_s[winner_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        rr_next_s = (winner_s == LAST_ID) ? '0 : winner_s + ID_W'(1);
        for (int i = 0; i < NUM_REQ; i++) begin
            win_a_s = (winner_s == ID_W'(i)) ? bus.req_a[i*DATA_W +: DATA_W] : win_a_s;
            win_b_s = (winner_s == ID_W'(i)) ? bus.req_b[i*DATA_W +: DATA_W] : win_b_s;
            rsp_data_s[i*OUT_W +: OUT_W] = slot_r[i];
        end
    end

    assign pop_s       = rsp_valid_r & bus.rsp_ready;
    assign retire_s    = tag_vld_r[TAG_DEPTH-1];
    assign retire_id_s = tag_id_r[TAG_DEPTH-1];
    // Final carry-propagate add of the redundant tree output; overflow wraps silently.
    assign sum_s       = bus.tree_vec0 + bus.tree_vec1;

    // Round-robin pointer and launch registers toward the tree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r     <= '0;
            tree_valid_r <= 1'b0;
            tree_a_r     <= '0;
            tree_b_r     <= '0;
        end else if (grant_any_s) begin
            rr_ptr_r     <= rr_next_s;
            tree_valid_r <= 1'b1;
            tree_a_r     <= win_a_s;
            tree_b_r     <= win_b_s;
        end else begin
            tree_valid_r <= 1'b0;
        end
    end

    // Tag pipeline carrying requester IDs alongside the operands in the tree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_r <= '0;
            for (int s = 0; s < TAG_DEPTH; s++) begin
                tag_id_r[s] <= '0;
            end
        end else begin
            tag_vld_r   <= {tag_vld_r[TAG_DEPTH-2:0], grant_any_s};
            tag_id_r[0] <= winner_s;
            for (int s = 1; s < TAG_DEPTH; s++) begin
                tag_id_r[s] <= tag_id_r[s-1];
            end
        end
    end

    // Per-requester busy flags, response valids and result slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= '0;
            rsp_valid_r <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_s[i]) begin
                    busy_r[i] <= 1'b1;
                end else if (pop_s[i]) begin
                    busy_r[i] <= 1'b0;
                end else begin
                    busy_r[i] <= busy_r[i];
                end
                if (retire_s && (retire_id_s == ID_W'(i))) begin
                    rsp_valid_r[i] <= 1'b1;
                    slot_r[i]      <= sum_s;
                end else if (pop_s[i]) begin
                    rsp_valid_r[i] <= 1'b0;
                end else begin
                    rsp_valid_r[i] <= rsp_valid_r[i];
                end
            end
        end
    end

    assign bus.req_ready  = grant_s;
    assign bus.tree_valid = tree_valid_r;
    assign bus.tree_a     = tree_a_r;
    assign bus.tree_b     = tree_b_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_data   = rsp_data_s;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_dadda_tree_scheduler.sv
// Bench for dadda_tree_scheduler: a transaction-level model of grants, tree latency and response
// slots is compared with the DUT every cycle, plus hand-computed checks for directed scenarios.
module tb_dadda_tree_scheduler;
    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int OW  = 32;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    dadda_tree_scheduler_if #(.NUM_REQ(N), .DATA_W(DW), .OUT_W(OW)) bus ();

    dadda_tree_scheduler #(.NUM_REQ(N), .DATA_W(DW), .OUT_W(OW), .TREE_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int exp_w;

    // Model state: pointer, per-requester flags/slots, expected tree launch registers
    int            m_rr;
    bit            m_busy [N];
    bit            m_pend [N];
    logic [OW-1:0] m_data [N];
    bit            m_tv;
    logic [DW-1:0] m_ta, m_tb;

    typedef struct { int due; int id; logic [OW-1:0] sum; } launch_t;
    typedef struct { int due; logic [OW-1:0] v0; logic [OW-1:0] v1; } vec_t;
    launch_t flight [$];
    vec_t    tree_q [$];

    logic [N-1:0]  s_valid, s_rready;
    logic [DW-1:0] s_a [N];
    logic [DW-1:0] s_b [N];

    // Shared tree stand-in: splits the product into two addends; one operand value forces a wrap case.
    function automatic logic [63:0] tree_fn(logic [DW-1:0] a, logic [DW-1:0] b);
        logic [OW-1:0] prod, v1;
        if (a == 16'hABCD) return {32'hFFFF_FFFF, 32'h0000_0002};
        prod = OW'(a) * OW'(b);
        v1   = prod / 32'd3;
        return {prod - v1, v1};
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_rr = 0;
        m_tv = 1'b0;
        m_ta = '0;
        m_tb = '0;
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_data[i] = '0;
        end
        flight.delete();
    endtask

    // Drive this cycle's inputs, let them settle, then compare every output against the model.
    task automatic tick_begin();
        logic [N-1:0]  exp_ready, exp_rv, exp_busy;
        logic [63:0]   v;
        vec_t          e;
        if (!rst_n) model_clear();
        bus.req_valid = s_valid;
        bus.rsp_ready = s_rready;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*DW +: DW] = s_a[i];
            bus.req_b[i*DW +: DW] = s_b[i];
        end
        while (tree_q.size() > 0 && tree_q[0].due < cyc) void'(tree_q.pop_front());
        if (tree_q.size() > 0 && tree_q[0].due == cyc) begin
            bus.tree_vec0 = tree_q[0].v0;
            bus.tree_vec1 = tree_q[0].v1;
            void'(tree_q.pop_front());
        end else begin
            bus.tree_vec0 = $urandom;
            bus.tree_vec1 = $urandom;
        end
        #2;
        exp_w = -1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (exp_w < 0 && s_valid[i] && !m_busy[i]) exp_w = i;
            end
        end
        exp_ready = '0;
        if (exp_w >= 0) exp_ready[exp_w] = 1'b1;
        check("req_ready", bus.req_ready, exp_ready);
        check("tree_valid", bus.tree_valid, m_tv);
        check("tree_a", bus.tree_a, m_ta);
        check("tree_b", bus.tree_b, m_tb);
        for (int i = 0; i < N; i++) begin
            exp_rv[i]   = m_pend[i];
            exp_busy[i] = m_busy[i];
            check($sformatf("rsp_data%0d", i), bus.rsp_data[i*OW +: OW], m_data[i]);
        end
        check("rsp_valid", bus.rsp_valid, exp_rv);
        check("busy", bus.busy, exp_busy);
        if (bus.tree_valid === 1'b1) begin
            v     = tree_fn(bus.tree_a, bus.tree_b);
            e.due = cyc + LAT;
            e.v0  = v[63:32];
            e.v1  = v[31:0];
            tree_q.push_back(e);
        end
    endtask

    // Advance the model across the clock edge, then move to the next cycle.
    task automatic tick_end();
        launch_t     l;
        logic [63:0] v;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i] && s_rready[i]) begin
                    m_pend[i] = 1'b0;
                    m_busy[i] = 1'b0;
                end
            end
            if (flight.size() > 0 && flight[0].due == cyc + 1) begin
                m_pend[flight[0].id] = 1'b1;
                m_data[flight[0].id] = flight[0].sum;
                void'(flight.pop_front());
            end
            if (exp_w >= 0) begin
                m_busy[exp_w] = 1'b1;
                m_rr  = (exp_w + 1) % N;
                m_tv  = 1'b1;
                m_ta  = s_a[exp_w];
                m_tb  = s_b[exp_w];
                v     = tree_fn(s_a[exp_w], s_b[exp_w]);
                l.due = cyc + 2 + LAT;
                l.id  = exp_w;
                l.sum = v[63:32] + v[31:0];
                flight.push_back(l);
            end else begin
                m_tv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        tick_begin();
        tick_end();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int others;
        s_valid  = '0;
        s_rready = '0;
        for (int i = 0; i < N; i++) begin
            s_a[i] = '0;
            s_b[i] = '0;
        end
        model_clear();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset state: requests present but nothing granted or valid
        s_valid = 4'b1111;
        tick_begin();
        check("rst_ready", bus.req_ready, 4'b0000);
        check("rst_tree_valid", bus.tree_valid, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        check("rst_busy", bus.busy, 4'b0000);
        tick_end();
        rst_n   = 1'b1;
        s_valid = '0;
        step();

        // Single op: 3*5 through the tree, vec0=10 vec1=5
        s_rready = 4'b1111;
        s_a[0] = 16'd3;
        s_b[0] = 16'd5;
        for (int r = 0; r < 7; r++) begin
            s_valid = (r == 0) ? 4'b0001 : 4'b0000;
            tick_begin();
            if (r == 0) check("t1_grant", bus.req_ready, 4'b0001);
            if (r == 1) check("t1_tree_valid", bus.tree_valid, 1'b1);
            if (r == 1) check("t1_tree_a", bus.tree_a, 16'd3);
            if (r == 3) check("t1_not_yet", bus.rsp_valid, 4'b0000);
            if (r == 4) check("t1_rsp_valid", bus.rsp_valid, 4'b0001);
            if (r == 4) check("t1_rsp_data", bus.rsp_data[0 +: OW], 32'd15);
            if (r == 5) check("t1_busy_clear", bus.busy, 4'b0000);
            tick_end();
        end

        // Round-robin fairness with immediate pops
        do_reset();
        for (int i = 0; i < N; i++) begin
            s_a[i] = DW'(i + 1);
            s_b[i] = DW'(16'h0100 * (i + 1));
        end
        s_valid  = 4'b1111;
        s_rready = 4'b1111;
        for (int r = 0; r < 16; r++) begin
            logic [N-1:0] onehot;
            onehot = '0;
            if (r < 4) onehot[r] = 1'b1;
            tick_begin();
            if (r <= 4) check($sformatf("rr_grant%0d", r), bus.req_ready, onehot);
            tick_end();
        end

        // Response back-pressure on requester 2
        do_reset();
        s_a[2]   = 16'd7;
        s_b[2]   = 16'd9;
        s_rready = 4'b1011;
        others   = 0;
        for (int r = 0; r < 18; r++) begin
            s_valid = (r == 0) ? 4'b0100 : 4'b1111;
            if (r == 16) s_rready = 4'b1111;
            tick_begin();
            if (r == 0) check("bp_grant", bus.req_ready, 4'b0100);
            if (r >= 1 && r <= 16) check("bp_no_regrant", bus.req_ready[2], 1'b0);
            if (r >= 4 && r <= 16) check("bp_pending", bus.rsp_valid[2], 1'b1);
            if (r >= 4) check("bp_data", bus.rsp_data[2*OW +: OW], 32'd63);
            if (r == 17) check("bp_popped", bus.rsp_valid[2], 1'b0);
            if (r >= 1 && r <= 15 && (bus.req_ready[1:0] != 2'b00 || bus.req_ready[3])) others++;
            tick_end();
        end
        check("bp_others_served", (others >= 3), 1'b1);

        // Wrap-around: pointer at 3 with requesters 1 and 3 valid
        do_reset();
        for (int r = 0; r < 8; r++) begin
            s_valid = (r == 0) ? 4'b0100 : (r <= 2) ? 4'b1010 : 4'b0000;
            tick_begin();
            if (r == 1) check("wrap_3_first", bus.req_ready, 4'b1000);
            if (r == 2) check("wrap_then_1", bus.req_ready, 4'b0010);
            tick_end();
        end

        // Final add wraps modulo 2^32
        do_reset();
        s_a[1] = 16'hABCD;
        s_b[1] = 16'h0003;
        for (int r = 0; r < 6; r++) begin
            s_valid = (r == 0) ? 4'b0010 : 4'b0000;
            tick_begin();
            if (r == 4) check("mod_valid", bus.rsp_valid, 4'b0010);
            if (r == 4) check("mod_data", bus.rsp_data[1*OW +: OW], 32'h0000_0001);
            tick_end();
        end

        // Reset one cycle after a launch; late vectors must be ignored
        do_reset();
        s_a[0] = 16'd3;
        s_b[0] = 16'd5;
        for (int r = 0; r < 11; r++) begin
            s_valid = (r == 0) ? 4'b0001 : 4'b0000;
            rst_n   = (r == 2) ? 1'b0 : 1'b1;
            tick_begin();
            if (r == 1) check("mf_launch", bus.tree_valid, 1'b1);
            if (r == 2) check("mf_tree_valid", bus.tree_valid, 1'b0);
            if (r == 2) check("mf_busy", bus.busy, 4'b0000);
            if (r >= 2) check("mf_no_rsp", bus.rsp_valid, 4'b0000);
            tick_end();
        end
        rst_n = 1'b1;

        // Mixed random traffic against the model
        do_reset();
        for (int r = 0; r < 80; r++) begin
            s_valid  = N'($urandom);
            s_rready = N'($urandom);
            for (int i = 0; i < N; i++) begin
                s_a[i] = DW'($urandom);
                s_b[i] = DW'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
